fetch_decode_unit: RTL and testbench

//  Upstream control stage for the register-file + ALU datapath. Holds a small program in
//  an internal instruction memory, fetches it sequentially from PC=0 and decodes each word

---
 rtl/fetch_decode_pkg.sv | 24 ++
 rtl/fetch_decode_unit_instr_mem.sv | 37 +++
 rtl/fetch_decode_unit.sv | 119 +++++++++++
 tb/tb_fetch_decode_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode stage: instruction field positions
// and the sequencer state encoding.
package fetch_decode_pkg;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 29;
  localparam int RD_MSB   = 28;
  localparam int RD_LSB   = 24;
  localparam int RS1_MSB  = 23;
  localparam int RS1_LSB  = 19;
  localparam int RS2_MSB  = 18;
  localparam int RS2_LSB  = 14;
  localparam int WE_BIT   = 13;
  localparam int HALT_BIT = 12;
  localparam int RSV_MSB  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_decode_unit_instr_mem.sv
// Program store: one write port, registered read port. The array is never
// cleared; only the read-data register returns to zero on reset.
module instr_mem #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read register doubles as the instruction register and holds while i_re is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fetch_decode_unit.sv
// Sequential program fetch and decode: one instruction issued every two clocks,
// Start/Busy/Done handshake, Stall holds the issuing instruction.
module fetch_decode_unit
  import fetch_decode_pkg::*;
#(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Load_en,
  input  logic [PC_W-1:0]    Load_addr,
  input  logic [INSTR_W-1:0] Load_data,
  output logic               RegWrite,
  output logic [4:0]         Addr_op1,
  output logic [4:0]         Addr_op2,
  output logic [4:0]         Addr_Destino,
  output logic [2:0]         Operacion,
  output logic               Busy,
  output logic               Done,
  output logic [PC_W-1:0]    PC_out
);

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic                r_busy;
  logic                r_done;

  logic [INSTR_W-1:0]  w_ir;
  logic                w_mem_we;
  logic                w_fetch;
  logic                w_issue;
  logic                w_we_flag;
  logic                w_halt;
  logic                w_last;
  logic [RSV_MSB:0]    w_unused_rsv;

  assign w_mem_we = (r_state == IDLE) && Load_en;
  assign w_fetch  = (r_state == FETCH);
  assign w_issue  = (r_state == ISSUE);

  instr_mem #(
    .ADDR_W (PC_W),
    .DATA_W (INSTR_W)
  ) u_imem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_mem_we),
    .i_waddr (Load_addr),
    .i_wdata (Load_data),
    .i_re    (w_fetch),
    .i_raddr (r_pc),
    .o_rdata (w_ir)
  );

  assign w_we_flag    = w_ir[WE_BIT];
  assign w_halt       = w_ir[HALT_BIT];
  assign w_unused_rsv = w_ir[RSV_MSB:0];
  assign w_last       = (r_pc == {PC_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_pc    <= '0;
            r_state <= FETCH;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          r_state <= ISSUE;
          r_busy  <= 1'b1;
        end
        ISSUE: begin
          // The last address ends the program so the PC never wraps.
          if (!Stall) begin
            if (w_halt || w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_pc    <= r_pc + 1'b1;
              r_state <= FETCH;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign RegWrite     = w_issue && w_we_flag && !w_halt && !Stall;
  assign Operacion    = w_issue ? w_ir[OP_MSB:OP_LSB]   : '0;
  assign Addr_Destino = w_issue ? w_ir[RD_MSB:RD_LSB]   : '0;
  assign Addr_op1     = w_issue ? w_ir[RS1_MSB:RS1_LSB] : '0;
  assign Addr_op2     = w_issue ? w_ir[RS2_MSB:RS2_LSB] : '0;
  assign Busy         = r_busy;
  assign Done         = r_done;
  assign PC_out       = r_pc;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed self-checking bench for fetch_decode_unit.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic        Stall;
  logic        Load_en;
  logic [4:0]  Load_addr;
  logic [31:0] Load_data;
  logic        RegWrite;
  logic [4:0]  Addr_op1;
  logic [4:0]  Addr_op2;
  logic [4:0]  Addr_Destino;
  logic [2:0]  Operacion;
  logic        Busy;
  logic        Done;
  logic [4:0]  PC_out;

  int n_cmp = 0;
  int n_err = 0;
  int rw_cnt = 0;
  int done_cnt = 0;
  int rw_base;
  int done_base;

  // ADD r3 <- r1,r2 (op 1, WE) with junk in the reserved field
  localparam logic [31:0] I_ADD   = 32'h2308_AABC;
  localparam logic [31:0] I_HALT  = 32'h0000_1000;
  // op 5, rd 7, rs1 9, rs2 10, WE=0
  localparam logic [31:0] I_NOWE  = 32'hA74A_8000;
  // rd 4, WE=1, HALT=1
  localparam logic [31:0] I_HALTW = 32'h0400_3000;

  fetch_decode_unit #(
    .PC_W    (5),
    .INSTR_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Start        (Start),
    .Stall        (Stall),
    .Load_en      (Load_en),
    .Load_addr    (Load_addr),
    .Load_data    (Load_data),
    .RegWrite     (RegWrite),
    .Addr_op1     (Addr_op1),
    .Addr_op2     (Addr_op2),
    .Addr_Destino (Addr_Destino),
    .Operacion    (Operacion),
    .Busy         (Busy),
    .Done         (Done),
    .PC_out       (PC_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (RegWrite === 1'b1) rw_cnt++;
    if (Done === 1'b1) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    Load_en   = 1'b1;
    Load_addr = a;
    Load_data = d;
    cyc();
    Load_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Stall = 1'b0; Load_en = 1'b0;
    Load_addr = '0; Load_data = '0;
    cyc(); cyc();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_pc", 32'(PC_out), 32'd0);
    chk("rst_rw", 32'(RegWrite), 32'd0);
    chk("rst_rd", 32'(Addr_Destino), 32'd0);
    rst = 1'b0;

    // Test 1: ADD then HALT
    load(5'd0, I_ADD);
    load(5'd1, I_HALT);
    rw_base = rw_cnt; done_base = done_cnt;
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("t1_fetch_busy", 32'(Busy), 32'd1);
    chk("t1_fetch_rw", 32'(RegWrite), 32'd0);
    chk("t1_fetch_rd", 32'(Addr_Destino), 32'd0);
    cyc();
    chk("t1_issue_rw", 32'(RegWrite), 32'd1);
    chk("t1_issue_rd", 32'(Addr_Destino), 32'd3);
    chk("t1_issue_op1", 32'(Addr_op1), 32'd1);
    chk("t1_issue_op2", 32'(Addr_op2), 32'd2);
    chk("t1_issue_opc", 32'(Operacion), 32'd1);
    chk("t1_issue_pc", 32'(PC_out), 32'd0);
    cyc();
    chk("t1_fetch2_rw", 32'(RegWrite), 32'd0);
    chk("t1_fetch2_pc", 32'(PC_out), 32'd1);
    cyc();
    chk("t1_halt_rw", 32'(RegWrite), 32'd0);
    chk("t1_halt_done", 32'(Done), 32'd0);
    chk("t1_halt_busy", 32'(Busy), 32'd1);
    cyc();
    chk("t1_done", 32'(Done), 32'd1);
    chk("t1_done_busy", 32'(Busy), 32'd0);
    chk("t1_done_pc", 32'(PC_out), 32'd1);
    cyc();
    chk("t1_idle_done", 32'(Done), 32'd0);
    chk("t1_idle_busy", 32'(Busy), 32'd0);
    chk("t1_rw_count", 32'(rw_cnt - rw_base), 32'd1);
    chk("t1_done_count", 32'(done_cnt - done_base), 32'd1);

    // Test 2: three stalled ISSUE cycles
    rw_base = rw_cnt; done_base = done_cnt;
    Start = 1'b1; cyc(); Start = 1'b0; Stall = 1'b1;
    cyc();
    chk("t2_s1_rw", 32'(RegWrite), 32'd0);
    chk("t2_s1_rd", 32'(Addr_Destino), 32'd3);
    cyc();
    chk("t2_s2_rw", 32'(RegWrite), 32'd0);
    chk("t2_s2_op1", 32'(Addr_op1), 32'd1);
    chk("t2_s2_pc", 32'(PC_out), 32'd0);
    cyc();
    chk("t2_s3_rw", 32'(RegWrite), 32'd0);
    chk("t2_s3_op2", 32'(Addr_op2), 32'd2);
    chk("t2_s3_busy", 32'(Busy), 32'd1);
    Stall = 1'b0; #1;
    chk("t2_rel_rw", 32'(RegWrite), 32'd1);
    chk("t2_rel_rd", 32'(Addr_Destino), 32'd3);
    cyc();
    chk("t2_fetch_pc", 32'(PC_out), 32'd1);
    cyc(); cyc();
    chk("t2_done", 32'(Done), 32'd1);
    cyc();
    chk("t2_rw_count", 32'(rw_cnt - rw_base), 32'd1);
    chk("t2_done_count", 32'(done_cnt - done_base), 32'd1);

    // Test 4: WE=0 instruction, then HALT with WE=1
    load(5'd0, I_NOWE);
    load(5'd1, I_HALTW);
    rw_base = rw_cnt; done_base = done_cnt;
    Start = 1'b1; cyc(); Start = 1'b0;
    cyc();
    chk("t4_rw", 32'(RegWrite), 32'd0);
    chk("t4_rd", 32'(Addr_Destino), 32'd7);
    chk("t4_op1", 32'(Addr_op1), 32'd9);
    chk("t4_op2", 32'(Addr_op2), 32'd10);
    chk("t4_opc", 32'(Operacion), 32'd5);
    cyc(); cyc();
    chk("t4_haltw_rw", 32'(RegWrite), 32'd0);
    chk("t4_haltw_rd", 32'(Addr_Destino), 32'd4);
    cyc();
    chk("t4_done", 32'(Done), 32'd1);
    cyc();
    chk("t4_rw_count", 32'(rw_cnt - rw_base), 32'd0);
    chk("t4_done_count", 32'(done_cnt - done_base), 32'd1);

    // Test 5: reset during ISSUE, then rerun
    load(5'd0, I_ADD);
    load(5'd1, I_HALT);
    done_base = done_cnt;
    Start = 1'b1; cyc(); Start = 1'b0;
    cyc();
    chk("t5_pre_rw", 32'(RegWrite), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_rst_busy", 32'(Busy), 32'd0);
    chk("t5_rst_pc", 32'(PC_out), 32'd0);
    chk("t5_rst_rd", 32'(Addr_Destino), 32'd0);
    chk("t5_rst_rw", 32'(RegWrite), 32'd0);
    cyc();
    chk("t5_rst_nodone", 32'(Done), 32'd0);
    chk("t5_rst_done_count", 32'(done_cnt - done_base), 32'd0);
    rw_base = rw_cnt;
    Start = 1'b1; cyc(); Start = 1'b0;
    cyc();
    chk("t5_rerun_rw", 32'(RegWrite), 32'd1);
    chk("t5_rerun_rd", 32'(Addr_Destino), 32'd3);
    cyc(); cyc(); cyc();
    chk("t5_rerun_done", 32'(Done), 32'd1);
    cyc();
    chk("t5_rw_count", 32'(rw_cnt - rw_base), 32'd1);

    // Test 6: Start and Load_en while busy are ignored
    Start = 1'b1; cyc();
    Start = 1'b1; Load_en = 1'b1; Load_addr = 5'd0; Load_data = 32'hFFFF_FFFF;
    cyc();
    chk("t6_issue_rd", 32'(Addr_Destino), 32'd3);
    cyc();
    chk("t6_fetch_pc", 32'(PC_out), 32'd1);
    Start = 1'b0; Load_en = 1'b0;
    cyc(); cyc();
    chk("t6_done", 32'(Done), 32'd1);
    cyc();
    Start = 1'b1; cyc(); Start = 1'b0;
    cyc();
    chk("t6_mem_rd", 32'(Addr_Destino), 32'd3);
    chk("t6_mem_op1", 32'(Addr_op1), 32'd1);
    cyc(); cyc(); cyc(); cyc();

    // Test 3: full 32-word program without HALT
    for (int k = 0; k < 32; k++) begin
      load(5'(k), (32'(k) << 24) | 32'h0000_2000);
    end
    rw_base = rw_cnt; done_base = done_cnt;
    Start = 1'b1; cyc(); Start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      cyc();
      chk("t3_pc", 32'(PC_out), 32'(k));
      chk("t3_rd", 32'(Addr_Destino), 32'(k));
      cyc();
    end
    chk("t3_done", 32'(Done), 32'd1);
    chk("t3_done_pc", 32'(PC_out), 32'd31);
    cyc();
    chk("t3_idle_pc", 32'(PC_out), 32'd31);
    chk("t3_idle_busy", 32'(Busy), 32'd0);
    chk("t3_rw_count", 32'(rw_cnt - rw_base), 32'd32);
    chk("t3_done_count", 32'(done_cnt - done_base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
